// File: rtl/bht_update_table_pkg.sv
// Shared types and helpers for the branch history table.
//   bht_update_t     : branch resolution from execute {valid, pc, taken}
//   bht_prediction_t : prediction returned to fetch {valid, taken}
//   bht_state_e      : sweep FSM state (INIT clears the table, RUN is usable)
//   sat_cnt_next     : 2-bit saturating counter step
package bht_update_table_pkg;

  localparam int unsigned VLEN = 64;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CNT_WEAK_NT = 2'b01;
  localparam logic [1:0] CNT_WEAK_T  = 2'b10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bht_state_e;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  // Saturating step: never wraps past 11 or below 00.
  function automatic logic [1:0] sat_cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
    else       return (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bht_sweep_fsm.sv
// Clear-sweep controller for the branch history table.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   flush_i         : restart the sweep from entry 0
//   init_done_o     : table usable (state is RUN), registered
//   sweep_we_o      : write the cleared value into entry sweep_idx_o this cycle
//   sweep_idx_o     : entry being cleared
module bht_sweep_fsm
  import bht_update_table_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 64,
  parameter int unsigned IDX_W      = $clog2(NR_ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  output logic             init_done_o,
  output logic             sweep_we_o,
  output logic [IDX_W-1:0] sweep_idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

  bht_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sweep_we_o = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_we_o = 1'b1;
        idx_d      = idx_q + 1'b1;  // wraps to 0 after the last entry
        if (idx_q == LAST_IDX) state_d = ST_RUN;
      end
      default: ;
    endcase
    // A flush in either state restarts a full sweep from entry 0.
    if (flush_i) begin
      state_d = ST_INIT;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign init_done_o = (state_q == ST_RUN);
  assign sweep_idx_o = idx_q;

endmodule

// File: rtl/bht_update_table.sv
// Branch history table: one 2-bit saturating counter plus valid bit per entry.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   flush_i            : restart the clear sweep
//   debug_mode_i       : suppress updates while in debug mode
//   vpc_i              : fetch PC to predict (combinational lookup)
//   bht_update_i       : resolved conditional branch {valid, pc, taken}
//   bht_prediction_o   : {valid, taken} for vpc_i
//   init_done_o        : table usable (sweep finished)
// Both PCs index with pc[IDX_W:1]; bit 0 is ignored for compressed alignment.
module bht_update_table
  import bht_update_table_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 64,
  parameter int unsigned VLEN       = bht_update_table_pkg::VLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            debug_mode_i,
  input  logic [VLEN-1:0] vpc_i,
  input  bht_update_t     bht_update_i,
  output bht_prediction_t bht_prediction_o,
  output logic            init_done_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
  localparam int unsigned UPC_W = $bits(bht_update_i.pc);

  logic [NR_ENTRIES-1:0]       valid_q, valid_d;
  logic [NR_ENTRIES-1:0][1:0]  cnt_q, cnt_d;

  logic             sweep_we;
  logic [IDX_W-1:0] sweep_idx;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             upd_acc;
  logic             pred_valid;

  bht_sweep_fsm #(
    .NR_ENTRIES (NR_ENTRIES),
    .IDX_W      (IDX_W)
  ) u_sweep (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .init_done_o (init_done_o),
    .sweep_we_o  (sweep_we),
    .sweep_idx_o (sweep_idx)
  );

  assign rd_idx = vpc_i[IDX_W:1];
  assign wr_idx = bht_update_i.pc[IDX_W:1];

  // init_done_o already excludes INIT; flush_i drops the update in the flush cycle.
  assign upd_acc = bht_update_i.valid & ~debug_mode_i & init_done_o & ~flush_i;

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (sweep_we) begin
      valid_d[sweep_idx] = 1'b0;
      cnt_d[sweep_idx]   = CNT_WEAK_NT;
    end else if (upd_acc) begin
      valid_d[wr_idx] = 1'b1;
      // A fresh entry starts weak in the resolved direction rather than stepping from 01.
      if (!valid_q[wr_idx]) cnt_d[wr_idx] = bht_update_i.taken ? CNT_WEAK_T : CNT_WEAK_NT;
      else                  cnt_d[wr_idx] = sat_cnt_next(cnt_q[wr_idx], bht_update_i.taken);
    end
  end

  // Counters need no reset: the sweep rewrites every entry before RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
    cnt_q <= cnt_d;
  end

  // Reads the registered table, so a same-cycle update is seen only next cycle.
  assign pred_valid             = init_done_o & valid_q[rd_idx];
  assign bht_prediction_o.valid = pred_valid;
  assign bht_prediction_o.taken = pred_valid & cnt_q[rd_idx][1];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{vpc_i[VLEN-1:IDX_W+1], vpc_i[0],
                            bht_update_i.pc[UPC_W-1:IDX_W+1], bht_update_i.pc[0]};

endmodule
